// File: rtl/mdu_hilo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_hilo: iterative radix-2 multiply/divide unit owning the HI/LO regs.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_dz;

  logic               w_muldiv;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_muldiv = ~op[2];
  assign w_neg_a  = op[0] & a[WIDTH-1];
  assign w_neg_b  = op[0] & b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -a : a;
  assign w_mag_b  = w_neg_b ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}; a borrow restores.
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_step = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_neg = -r_acc;
  assign w_quo      = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_muldiv) begin
                r_div <= op[1];
                r_sa  <= w_neg_a;
                r_sb  <= w_neg_b;
                r_cnt <= '0;
                r_dz  <= op[1] & (b == '0);
                busy  <= 1'b1;
                if (op[1]) begin
                  r_opnd <= w_mag_b;
                  // Divide by zero bypasses iteration; FIX emits hi=a, lo=all ones.
                  if (b == '0) begin
                    r_acc   <= {a, {WIDTH{1'b1}}};
                    r_state <= S_FIX;
                  end else begin
                    r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                    r_state <= S_RUN;
                  end
                end else begin
                  r_opnd  <= w_mag_a;
                  r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                  r_state <= S_RUN;
                end
              end else if (op == 3'b100) begin
                hi <= a;
              end else if (op == 3'b101) begin
                lo <= a;
              end
            end
          end
          S_RUN: begin
            r_acc <= r_div ? w_div_step : w_mul_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) r_state <= S_FIX;
          end
          S_FIX: begin
            if (r_dz) begin
              {hi, lo} <= r_acc;
            end else if (r_div) begin
              hi <= w_rem;
              lo <= w_quo;
            end else if (r_sa ^ r_sb) begin
              {hi, lo} <= w_prod_neg;
            end else begin
              {hi, lo} <= r_acc;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// Scoreboard bench for mdu_hilo: a reference model predicts {hi,lo}; a monitor checks each done.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        prev_done = 1'b0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result: {hi, lo}
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [31:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: return {32'd0, x} * {32'd0, y};
      3'd1: return sx * sy;
      3'd2: if (y == 0) return {x, 32'hFFFF_FFFF}; else return {x % y, x / y};
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {r, q};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hilo_result", {hi, lo}, mon_e);
      end
    end
    prev_done <= done;
  end

  // Issue one op at the current negedge; returns in the done cycle for mul/div.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    logic [63:0] e;
    int k;
    bit got;
    e = ref_res(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    if (o <= 3'd3) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    if (o == 3'd4) m_hi = x;
    if (o == 3'd5) m_lo = x;
    if (o > 3'd3) begin
      chk("mt_nop_hilo", {hi, lo}, {m_hi, m_lo});
      chk("mt_nop_flags", {62'd0, busy, done}, 64'd0);
      return;
    end
    k = 1;
    got = 1'b0;
    while (!got && k < 100) begin
      if (done) begin
        got = 1'b1;
      end else begin
        chk("busy_in_flight", {63'd0, busy}, 64'd1);
        chk("hilo_stable", {hi, lo}, {m_hi, m_lo});
        if (k == poke) begin
          start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        k++;
      end
    end
    chk("done_seen", {63'd0, got}, 64'd1);
    chk("latency_edges", 64'(k - 1), (o[1] && y == 0) ? 64'd1 : 64'd33);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    if (got) {m_hi, m_lo} = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // flush beats start in the same cycle
    flush = 1'b1; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_drop", {62'd0, busy, done}, 64'd0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd2, 32'd100, 32'd7, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'h0000_1234, 32'd0, 0);
    run_op(3'd4, 32'hAAAA_5555, 32'd0, 0);
    run_op(3'd5, 32'h0F0F_0F0F, 32'd0, 0);
    run_op(3'd6, 32'h1111_1111, 32'd2, 0);
    run_op(3'd7, 32'h2222_2222, 32'd3, 0);

    // flush in RUN: no done, hi/lo untouched
    start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    chk("flush_quiet", {62'd0, busy, done}, 64'd0);

    // start while busy is ignored
    run_op(3'd2, 32'd1000, 32'd7, 5);

    // asynchronous reset mid-divide
    start = 1'b1; op = 3'd2; a = $urandom; b = $urandom | 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_flags", {62'd0, busy, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(3'd0, 32'd6, 32'd7, 0);

    repeat (40) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) rx = 32'($signed(8'($urandom)));
      if ($urandom_range(0, 3) == 0) ry = 32'($signed(6'($urandom)));
      if ($urandom_range(0, 7) == 0) ry = 32'd0;
      run_op(ro, rx, ry, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- The ALU only returns the truncated low word of a product and discards the remainder of a division.
- This block executes MULT/MULTU/DIV/DIVU/MTHI/MTLO over multiple cycles and holds the architectural HI/LO registers.
- The hazard unit reads `busy` to stall MFHI/MFLO and further mul/div issue.

Parameters:
- WIDTH, 32, operand and HI/LO width (must be even, ≥4).
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  issue strobe, sampled on the rising edge
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, others NOP
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  abort any in-flight operation
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO valid with the new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- **Reset:** asynchronous, active-low; reset = 0 forces state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation with no done pulse.
- **States:**
  - IDLE: accepts start.
  - RUN: one radix-2 iteration per cycle, WIDTH cycles.
  - FIX: sign correction and HI/LO write.
  - IDLE is re-entered after FIX.
- **Issue (start=1 in IDLE, sampled at edge E0):**
  - Capture the operation.
  - For signed ops, capture |a|, |b| and sign flags sa, sb; unsigned ops capture a and b as-is.
  - Go to RUN with counter=0; busy=1 from E0.
- **Multiply:** shift-add over the unsigned magnitudes into a 2·WIDTH accumulator. If sa^sb for MULT, FIX two's-complement negates the full 2·WIDTH product. {hi,lo} = product.
- **Divide:** restoring shift-subtract over the magnitudes.
  - FIX negates the quotient if sa^sb, and the remainder if sa.
  - lo = quotient, hi = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This follows from the magnitude scheme and needs no special case.
- **Divide by zero (b=0 at issue):** skip RUN and go straight to FIX. hi=a, lo={WIDTH{1}}, done pulses one cycle after E1.
- **Latency:**
  - Iterations occur on edges E1..E32 and FIX writes on E33.
  - busy=1 in the 33 cycles following E0.
  - done=1 and busy=0 in the cycle after E33.
  - Mul/div issue-to-done is 33 edges (WIDTH+1).
- **HI/LO stability:** hi and lo are written only at the FIX edge and never hold partial values.
- **MTHI/MTLO:** accepted in IDLE only. The register is written at E0 from a, with no busy and no done; the other register is unchanged.
- **start while busy:** ignored; no queueing, and the in-flight operation is unaffected. The hazard unit must not issue.
- **Op NOP codes (110, 111):** no effect.
- **flush:** has priority over everything except reset.
  - At the next edge: state=IDLE, busy=0, no done, hi/lo unchanged.
  - start and flush in the same cycle: flush wins and start is dropped.
  - flush in IDLE is a no-op.
- **done:** exactly one cycle wide; never asserted for MTHI/MTLO or an aborted operation.
- **Back-to-back:** a start in the same cycle as done (state IDLE) is accepted.
- **Sampling:** operands are sampled only at issue; later changes to a and b are ignored.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 edges after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then issue MULT 0x80000000 × 0x80000000 back-to-back in the done cycle -> hi=0x40000000, lo=0.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done after 2 edges; hi=0x1234, lo=0xFFFFFFFF.
- MTHI a=0xAAAA5555 then MTLO a=0x0F0F0F0F -> hi/lo update on the next edge, busy=0, done=0 throughout. Then start MULTU with flush at RUN cycle 10 -> busy drops next edge, hi/lo still 0xAAAA5555 / 0x0F0F0F0F, no done.
- Start DIVU; at cycle 5 pulse start with a new op (must be ignored); at cycle 20 assert reset=0 asynchronously between edges -> hi=lo=0, busy=0, done=0 immediately. After release, a new MULTU 6×7 -> lo=42, hi=0.
